// File: rtl/instr_queue_pkg.sv
// Shared definitions for the fetch-to-execute instruction queue.
// Holds the default word width, the bubble word and the update op encoding.
package instr_queue_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] BUBBLE = '0;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH,
    OP_FLUSH
  } iq_op_e;

endpackage

// File: rtl/iq_storage.sv
// Entry storage for the instruction queue: one write port, one async read.
// Contents are never cleared; the pointers decide what is reachable.
module iq_storage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [2*XLEN-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [2*XLEN-1:0] rdata
);

  logic [2*XLEN-1:0] mem [DEPTH];

  // write the tail entry when the queue accepts an instruction
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and execute.
// FIFO of {instr, pc} with flush, same-cycle push/pop and bubble output.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        instr,
  input  logic [XLEN-1:0]        pc_in,
  input  logic                   valid_in,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   exe_ready,
  output logic                   instr_valid,
  output logic [XLEN-1:0]        instruction,
  output logic [XLEN-1:0]        pc_to_exe,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] rd_data;
  iq_op_e            op;

  assign count       = cnt;
  assign instr_valid = (cnt != '0);
  // a full queue still accepts when the head drains this cycle
  assign in_ready    = ~rst & ((cnt < FULL) | exe_ready);
  assign push        = valid_in & in_ready & ~flush;
  assign pop         = instr_valid & exe_ready & ~flush;

  // classify this cycle's update; flush wins over everything
  always_comb begin
    op = OP_IDLE;
    if (flush)             op = OP_FLUSH;
    else if (push && pop)  op = OP_BOTH;
    else if (push)         op = OP_PUSH;
    else if (pop)          op = OP_POP;
  end

  // pointer and occupancy update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      unique case (op)
        OP_FLUSH: begin
          head <= '0;
          tail <= '0;
          cnt  <= '0;
        end
        OP_PUSH: begin
          tail <= tail + 1'b1;
          cnt  <= cnt + 1'b1;
        end
        OP_POP: begin
          head <= head + 1'b1;
          cnt  <= cnt - 1'b1;
        end
        OP_BOTH: begin
          head <= head + 1'b1;
          tail <= tail + 1'b1;
        end
        default: ;
      endcase
    end
  end

  iq_storage #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata ({instr, pc_in}),
    .raddr (head),
    .rdata (rd_data)
  );

  // head entry when valid, otherwise a bubble
  always_comb begin
    instruction = XLEN'(BUBBLE);
    pc_to_exe   = '0;
    if (instr_valid) begin
      instruction = rd_data[2*XLEN-1:XLEN];
      pc_to_exe   = rd_data[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue (XLEN 32, DEPTH 4).
// Each scenario task drives stimulus and checks the DUT against a queue model.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        valid_in;
  logic        in_ready;
  logic        flush;
  logic        exe_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_to_exe;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb [$];
  logic [63:0] exp_e;

  instr_queue dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .pc_in       (pc_in),
    .valid_in    (valid_in),
    .in_ready    (in_ready),
    .flush       (flush),
    .exe_ready   (exe_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc_to_exe   (pc_to_exe),
    .count       (count)
  );

  always #5 clk = ~clk;

  // drive one cycle and advance the scoreboard, sample point is edge+1
  task automatic cyc(input logic v, input logic [31:0] i,
                     input logic [31:0] p, input logic e,
                     input logic f);
    logic rdy, dpush, dpop;
    valid_in  = v;
    instr     = i;
    pc_in     = p;
    exe_ready = e;
    flush     = f;
    rdy   = (sb.size() < 4) || e;
    dpush = v && rdy && !f;
    dpop  = (sb.size() != 0) && e && !f;
    @(posedge clk);
    if (f) sb.delete();
    else begin
      if (dpop) void'(sb.pop_front());
      if (dpush) sb.push_back({i, p});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; exe_ready = 1'b0; flush = 1'b0;
    instr = 32'h13; pc_in = 32'h1000;
    #3;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instruction); end
    checks++; if (pc_to_exe !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", pc_to_exe); end
    @(posedge clk); @(posedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_hold_count got=%0d exp=0", count); end
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b0;
    sb.delete();
  endtask

  task automatic test_basic();
    cyc(1'b1, 32'h0000_0013, 32'h1000, 1'b0, 1'b0);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", instr_valid); end
    checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL basic_instr got=%h exp=00000013", instruction); end
    checks++; if (pc_to_exe !== 32'h1000) begin errors++; $display("FAIL basic_pc got=%h exp=00001000", pc_to_exe); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", count); end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_drain_count got=%0d exp=0", count); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL basic_bubble got=%h exp=0", instruction); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 32'hA000_0000 + k, 32'h1000 + 4 * k, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    cyc(1'b1, 32'hDEAD_BEEF, 32'h1010, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_fifth_count got=%0d exp=4", count); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pc_to_exe !== 32'h1000 + 4 * k) begin
        errors++; $display("FAIL full_drain_pc%0d got=%h exp=%h", k, pc_to_exe, 32'h1000 + 4 * k);
      end
      checks++;
      if (instruction !== 32'hA000_0000 + k) begin
        errors++; $display("FAIL full_drain_instr%0d got=%h exp=%h", k, instruction, 32'hA000_0000 + k);
      end
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL full_empty_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 32'hB000_0000 + k, 32'h2000 + 4 * k, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 32'hB000_0004 + k, 32'h2010 + 4 * k, 1'b1, 1'b0);
      exp_e = sb[0];
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=4", k, count); end
      checks++;
      if (pc_to_exe !== 32'h2004 + 4 * k) begin
        errors++; $display("FAIL b2b_pc%0d got=%h exp=%h", k, pc_to_exe, 32'h2004 + 4 * k);
      end
      checks++;
      if (instruction !== exp_e[63:32]) begin
        errors++; $display("FAIL b2b_instr%0d got=%h exp=%h", k, instruction, exp_e[63:32]);
      end
    end
    while (sb.size() != 0) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_one_entry();
    cyc(1'b1, 32'hC000_0001, 32'h3000, 1'b0, 1'b0);
    cyc(1'b1, 32'hC000_0002, 32'h3004, 1'b1, 1'b0);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL one_valid got=%b exp=1", instr_valid); end
    checks++; if (pc_to_exe !== 32'h3004) begin errors++; $display("FAIL one_pc got=%h exp=00003004", pc_to_exe); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL one_count got=%0d exp=1", count); end
  endtask

  task automatic test_stall();
    cyc(1'b1, 32'hC000_0003, 32'h3008, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (pc_to_exe !== 32'h3004 || instruction !== 32'hC000_0002) begin
        errors++; $display("FAIL stall_hold%0d got=%h/%h exp=00003004/c0000002", k, pc_to_exe, instruction);
      end
    end
  endtask

  task automatic test_flush();
    cyc(1'b1, 32'hC000_0004, 32'h300C, 1'b0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    cyc(1'b1, 32'hC000_0005, 32'h3010, 1'b1, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", instr_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL flush_instr got=%h exp=0", instruction); end
    cyc(1'b1, 32'hC000_0006, 32'h4000, 1'b0, 1'b0);
    checks++; if (pc_to_exe !== 32'h4000) begin errors++; $display("FAIL flush_refill_pc got=%h exp=00004000", pc_to_exe); end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 32'hC000_0007, 32'h4004, 1'b0, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
    valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", instr_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
    #1 rst = 1'b0;
    sb.delete();
    cyc(1'b1, 32'hE000_0001, 32'h5000, 1'b0, 1'b0);
    checks++; if (pc_to_exe !== 32'h5000 || count !== 3'd1) begin
      errors++; $display("FAIL areset_first_push got=%h/%0d exp=00005000/1", pc_to_exe, count);
    end
  endtask

  task automatic test_random();
    logic v, e, f;
    logic [31:0] pc = 32'h8000;
    for (int n = 0; n < 10000; n++) begin
      v = ($urandom_range(99) < 70);
      e = ($urandom_range(99) < 50);
      f = ($urandom_range(31) == 0);
      exe_ready = e;
      #1;
      checks++;
      if (in_ready !== ((sb.size() < 4) || e)) begin
        errors++; $display("FAIL rnd_in_ready@%0d got=%b exp=%b", n, in_ready, (sb.size() < 4) || e);
      end
      cyc(v, $urandom, pc, e, f);
      if (v && !f) pc = pc + 4;
      checks++;
      if (count !== 3'(sb.size()) || count > 3'd4) begin
        errors++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", n, count, sb.size());
      end
      checks++;
      if (sb.size() != 0) begin
        exp_e = sb[0];
        if (instr_valid !== 1'b1 || instruction !== exp_e[63:32] || pc_to_exe !== exp_e[31:0]) begin
          errors++; $display("FAIL rnd_head@%0d got=%b/%h/%h exp=1/%h/%h", n, instr_valid, instruction, pc_to_exe, exp_e[63:32], exp_e[31:0]);
        end
      end else if (instr_valid !== 1'b0 || instruction !== 32'h0 || pc_to_exe !== 32'h0) begin
        errors++; $display("FAIL rnd_empty@%0d got=%b/%h/%h exp=0/0/0", n, instr_valid, instruction, pc_to_exe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_one_entry();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter XLEN, default 32, width of instruction word and PC.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port instr  input  XLEN  fetched instruction word.
REQ-006 Port pc_in  input  XLEN  PC of the fetched instruction.
REQ-007 Port valid_in  input  1  fetch offers instr/pc_in this cycle.
REQ-008 Port in_ready  output  1  queue accepts an offer this cycle.
REQ-009 Port flush  input  1  synchronous discard of all entries (branch/redirect).
REQ-010 Port exe_ready  input  1  execute stage consumes head entry this cycle.
REQ-011 Port instr_valid  output  1  head entry valid.
REQ-012 Port instruction  output  XLEN  head instruction word.
REQ-013 Port pc_to_exe  output  XLEN  head PC.
REQ-014 Port count  output  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-015 push = valid_in & in_ready & ~flush; pop = instr_valid & exe_ready & ~flush.
REQ-016 in_ready = ~rst & ((count < DEPTH) | exe_ready) -- full queue accepts when head drains the same cycle.
REQ-017 instr_valid = (count != 0); instruction/pc_to_exe = head entry when valid, all-zero bubble when empty.
REQ-018 Latency: entry pushed at edge N is visible on outputs after edge N (one cycle), when it is head.
REQ-019 Push writes {instr, pc_in} at tail pointer; tail advances by 1, wrapping DEPTH-1 -> 0.
REQ-020 Pop advances head pointer by 1, wrapping DEPTH-1 -> 0.
REQ-021 count: push only +1; pop only -1; push & pop unchanged; neither unchanged.
REQ-022 Push & pop on a full queue: both pointers advance, count stays DEPTH, no data lost.
REQ-023 Push & pop on a one-entry queue: outputs show new entry next cycle, instr_valid stays 1.
REQ-024 Head outputs stable while instr_valid & ~exe_ready.
REQ-025 Flush: next edge head = tail = 0, count = 0; overrides any push/pop in that cycle.
REQ-026 Entry order strictly FIFO; no entry duplicated or skipped across wrap.
REQ-027 Storage contents not cleared by flush; unreachable entries never appear on outputs.

Reset
REQ-028 While rst high: count 0, head/tail 0, instr_valid 0, instruction 0, pc_to_exe 0, in_ready 0.
REQ-029 Reset asserted mid-operation discards all entries immediately, independent of clk.
REQ-030 First push accepted on the first rising edge after rst deasserts.

Structure
REQ-031 Shared package holds XLEN default and the bubble constant (all-zero instruction word).
REQ-032 Storage array is one sub-module, iq_storage: DEPTH x 2*XLEN, one write port, one async read port.
REQ-033 Pointer/count control stays in instr_queue; no combinational path from instr/pc_in to outputs.

Verification
REQ-034 Reset, push 0x00000013/pc 0x1000 with exe_ready 0 -> next cycle instr_valid 1, instruction 0x00000013, pc_to_exe 0x1000, count 1.
REQ-035 Push 4 (DEPTH 4) with exe_ready 0 -> count 4, in_ready 0; 5th offer ignored; drain returns pcs 0x1000,0x1004,0x1008,0x100C in order.
REQ-036 Full queue, valid_in 1 and exe_ready 1 for 10 cycles -> count stays 4, outputs walk pcs in order across pointer wrap.
REQ-037 count 3, flush with valid_in 1 and exe_ready 1 -> next cycle count 0, instr_valid 0, instruction 0.
REQ-038 rst pulsed asynchronously between edges with count 2 -> instr_valid and count 0 before next edge, in_ready 0 during rst.
REQ-039 Random valid_in/exe_ready/flush for 10k cycles vs scoreboard -> no order mismatch, count never exceeds DEPTH.
